// File: rtl/definitions.sv
// Shared types for the ALU and its command controller: ALU opcode set, command
// kinds and controller FSM states.
package definitions;

  typedef enum logic [2:0] {
    ALU_O_ADD  = 3'd0,
    ALU_O_SUB  = 3'd1,
    ALU_O_AND  = 3'd2,
    ALU_O_OR   = 3'd3,
    ALU_O_XOR  = 3'd4,
    ALU_O_NOR  = 3'd5,
    ALU_O_SLT  = 3'd6,
    ALU_O_SLTU = 3'd7
  } alu_operation;

  // Two-bit encoding so undefined kinds exist and can be folded onto CMD_LDI.
  typedef enum logic [1:0] {
    CMD_ALU = 2'd0,
    CMD_LDI = 2'd1
  } cmd_kind_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU driven by alu_cmd_ctrl; all arithmetic wraps modulo 2^DW.
module alu
  import definitions::*;
#(
  parameter int unsigned DW = 32
) (
  input  alu_operation  op_i,
  input  logic [DW-1:0] rs_i,
  input  logic [DW-1:0] rt_i,
  output logic [DW-1:0] result_o,
  output logic          zero
);

  logic lt_signed;
  logic lt_unsigned;

  assign lt_signed   = $signed(rs_i) < $signed(rt_i);
  assign lt_unsigned = rs_i < rt_i;

  always_comb begin
    result_o = '0;
    unique case (op_i)
      ALU_O_ADD:  result_o = rs_i + rt_i;
      ALU_O_SUB:  result_o = rs_i - rt_i;
      ALU_O_AND:  result_o = rs_i & rt_i;
      ALU_O_OR:   result_o = rs_i | rt_i;
      ALU_O_XOR:  result_o = rs_i ^ rt_i;
      ALU_O_NOR:  result_o = ~(rs_i | rt_i);
      ALU_O_SLT:  result_o = {{(DW-1){1'b0}}, lt_signed};
      ALU_O_SLTU: result_o = {{(DW-1){1'b0}}, lt_unsigned};
      default:    result_o = '0;
    endcase
  end

  assign zero = (result_o == '0);

endmodule

// File: rtl/alu_regfile.sv
// NREGS x DW register file: two asynchronous read ports, one synchronous write
// port, entry 0 hardwired to zero, asynchronous active-low clear.
module alu_regfile #(
  parameter int unsigned NREGS = 8,
  parameter int unsigned DW    = 32,
  localparam int unsigned REG_W = $clog2(NREGS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [REG_W-1:0] ra_addr_i,
  output logic [DW-1:0]    ra_data_o,
  input  logic [REG_W-1:0] rb_addr_i,
  output logic [DW-1:0]    rb_data_o,
  input  logic             we_i,
  input  logic [REG_W-1:0] wa_i,
  input  logic [DW-1:0]    wd_i
);

  logic [DW-1:0] mem_q [NREGS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (wa_i != '0)) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  assign ra_data_o = (ra_addr_i == '0) ? '0 : mem_q[ra_addr_i];
  assign rb_data_o = (rb_addr_i == '0) ? '0 : mem_q[rb_addr_i];

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Command controller in front of the combinational ALU: accepts ALU/LDI
// commands, runs one execute cycle, writes back rd and returns a response.
module alu_cmd_ctrl
  import definitions::*;
#(
  parameter int unsigned NREGS = 8,
  parameter int unsigned DW    = 32,
  localparam int unsigned REG_W = $clog2(NREGS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  cmd_kind_e        cmd_kind_i,
  input  alu_operation     cmd_op_i,
  input  logic [REG_W-1:0] cmd_rd_i,
  input  logic [REG_W-1:0] cmd_rs_i,
  input  logic [REG_W-1:0] cmd_rt_i,
  input  logic [DW-1:0]    cmd_imm_i,
  output alu_operation     alu_op_o,
  output logic [DW-1:0]    alu_rs_o,
  output logic [DW-1:0]    alu_rt_o,
  input  logic [DW-1:0]    alu_result_i,
  input  logic             alu_zero_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [DW-1:0]    rsp_data_o,
  output logic             rsp_zero_o,
  output logic [REG_W-1:0] rsp_rd_o
);

  ctrl_state_e state_q, state_d;

  logic             is_alu_q;
  alu_operation     op_q;
  logic [REG_W-1:0] rd_q;
  logic [DW-1:0]    imm_q;
  logic [DW-1:0]    opa_q;
  logic [DW-1:0]    opb_q;
  logic [DW-1:0]    rsp_data_q;
  logic             rsp_zero_q;
  logic [REG_W-1:0] rsp_rd_q;

  logic             accept;
  logic             exec;
  logic [DW-1:0]    exec_data;
  logic             exec_zero;
  logic [DW-1:0]    rf_rs_data;
  logic [DW-1:0]    rf_rt_data;

  alu_regfile #(
    .NREGS(NREGS),
    .DW   (DW)
  ) u_regfile (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .ra_addr_i(cmd_rs_i),
    .ra_data_o(rf_rs_data),
    .rb_addr_i(cmd_rt_i),
    .rb_data_o(rf_rt_data),
    .we_i     (exec),
    .wa_i     (rd_q),
    .wd_i     (exec_data)
  );

  // FSM next state and outputs; handshake outputs depend only on state_q.
  always_comb begin
    state_d     = state_q;
    cmd_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    alu_op_o    = ALU_O_ADD;
    alu_rs_o    = '0;
    alu_rt_o    = '0;
    accept      = 1'b0;
    exec        = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          accept  = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        exec = 1'b1;
        if (is_alu_q) begin
          alu_op_o = op_q;
          alu_rs_o = opa_q;
          alu_rt_o = opb_q;
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // LDI bypasses the ALU entirely.
  always_comb begin
    exec_data = imm_q;
    exec_zero = (imm_q == '0);
    if (is_alu_q) begin
      exec_data = alu_result_i;
      exec_zero = alu_zero_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      is_alu_q <= 1'b0;
      op_q     <= ALU_O_ADD;
      rd_q     <= '0;
      imm_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
    end else if (accept) begin
      // Any kind other than CMD_ALU executes as an immediate load.
      is_alu_q <= (cmd_kind_i == CMD_ALU);
      op_q     <= cmd_op_i;
      rd_q     <= cmd_rd_i;
      imm_q    <= cmd_imm_i;
      opa_q    <= rf_rs_data;
      opb_q    <= rf_rt_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_data_q <= '0;
      rsp_zero_q <= 1'b0;
      rsp_rd_q   <= '0;
    end else if (exec) begin
      rsp_data_q <= exec_data;
      rsp_zero_q <= exec_zero;
      rsp_rd_q   <= rd_q;
    end
  end

  assign rsp_data_o = rsp_data_q;
  assign rsp_zero_o = rsp_zero_q;
  assign rsp_rd_o   = rsp_rd_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Scoreboard bench for alu_cmd_ctrl with the ALU attached: stimulus pushes the
// expected response, a negedge monitor pops and compares on each handshake.
module tb_alu_cmd_ctrl;
  import definitions::*;

  localparam int unsigned NREGS = 8;
  localparam int unsigned DW    = 32;
  localparam int unsigned REG_W = $clog2(NREGS);

  typedef struct {
    logic [DW-1:0]    data;
    logic             zero;
    logic [REG_W-1:0] rd;
  } exp_t;

  logic             clk_i;
  logic             rst_ni;
  logic             cmd_valid_i;
  logic             cmd_ready_o;
  cmd_kind_e        cmd_kind_i;
  alu_operation     cmd_op_i;
  logic [REG_W-1:0] cmd_rd_i;
  logic [REG_W-1:0] cmd_rs_i;
  logic [REG_W-1:0] cmd_rt_i;
  logic [DW-1:0]    cmd_imm_i;
  alu_operation     alu_op_o;
  logic [DW-1:0]    alu_rs_o;
  logic [DW-1:0]    alu_rt_o;
  logic [DW-1:0]    alu_result;
  logic             alu_zero;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [DW-1:0]    rsp_data_o;
  logic             rsp_zero_o;
  logic [REG_W-1:0] rsp_rd_o;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  alu_cmd_ctrl #(
    .NREGS(NREGS),
    .DW   (DW)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_kind_i  (cmd_kind_i),
    .cmd_op_i    (cmd_op_i),
    .cmd_rd_i    (cmd_rd_i),
    .cmd_rs_i    (cmd_rs_i),
    .cmd_rt_i    (cmd_rt_i),
    .cmd_imm_i   (cmd_imm_i),
    .alu_op_o    (alu_op_o),
    .alu_rs_o    (alu_rs_o),
    .alu_rt_o    (alu_rt_o),
    .alu_result_i(alu_result),
    .alu_zero_i  (alu_zero),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
    .rsp_zero_o  (rsp_zero_o),
    .rsp_rd_o    (rsp_rd_o)
  );

  alu #(
    .DW(DW)
  ) u_alu (
    .op_i    (alu_op_o),
    .rs_i    (alu_rs_o),
    .rt_i    (alu_rt_o),
    .result_o(alu_result),
    .zero    (alu_zero)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Handshake completes on the next rising edge; all inputs change at posedge+1.
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && rsp_valid_o === 1'b1 && rsp_ready_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got data 0x%08h rd %0d, expected no response",
                 rsp_data_o, rsp_rd_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_data", rsp_data_o, mon_e.data);
        chk("rsp_zero", {31'd0, rsp_zero_o}, {31'd0, mon_e.zero});
        chk("rsp_rd", {29'd0, rsp_rd_o}, {29'd0, mon_e.rd});
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Returns at posedge+1 right after the accepting edge, i.e. inside S_EXEC.
  task automatic issue(input cmd_kind_e kind, input alu_operation op,
                       input logic [REG_W-1:0] rd, input logic [REG_W-1:0] rs,
                       input logic [REG_W-1:0] rt, input logic [DW-1:0] imm,
                       input logic push, input logic [DW-1:0] ed, input logic ez);
    exp_t e;
    bit   done;
    if (push) begin
      e.data = ed;
      e.zero = ez;
      e.rd   = rd;
      exp_q.push_back(e);
    end
    cmd_valid_i = 1'b1;
    cmd_kind_i  = kind;
    cmd_op_i    = op;
    cmd_rd_i    = rd;
    cmd_rs_i    = rs;
    cmd_rt_i    = rt;
    cmd_imm_i   = imm;
    done        = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk_i);
      done = (cmd_ready_o === 1'b1);
      step();
    end
    cmd_valid_i = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got cmd_ready_o low, expected accept within 40 cycles");
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk_i);
      done = (exp_q.size() == 0) && (cmd_ready_o === 1'b1);
      step();
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending responses, expected 0", exp_q.size());
    end
  endtask

  initial begin
    rst_ni      = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_kind_i  = CMD_LDI;
    cmd_op_i    = ALU_O_ADD;
    cmd_rd_i    = '0;
    cmd_rs_i    = '0;
    cmd_rt_i    = '0;
    cmd_imm_i   = '0;
    rsp_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
    chk("reset_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("reset_rsp_data", rsp_data_o, 32'd0);
    chk("reset_rsp_zero", {31'd0, rsp_zero_o}, 32'd0);
    chk("reset_rsp_rd", {29'd0, rsp_rd_o}, 32'd0);
    chk("reset_alu_op", {29'd0, alu_op_o}, {29'd0, ALU_O_ADD});
    chk("reset_alu_rs", alu_rs_o, 32'd0);
    rst_ni = 1'b1;
    step();

    // Basic loads and an add, observing the ALU drive during S_EXEC.
    issue(CMD_LDI, ALU_O_ADD, 3'd1, 3'd0, 3'd0, 32'd5, 1'b1, 32'd5, 1'b0);
    issue(CMD_LDI, ALU_O_ADD, 3'd2, 3'd0, 3'd0, 32'd3, 1'b1, 32'd3, 1'b0);
    issue(CMD_ALU, ALU_O_ADD, 3'd3, 3'd1, 3'd2, 32'd0, 1'b1, 32'd8, 1'b0);
    @(negedge clk_i);
    chk("exec_alu_op", {29'd0, alu_op_o}, {29'd0, ALU_O_ADD});
    chk("exec_alu_rs", alu_rs_o, 32'd5);
    chk("exec_alu_rt", alu_rt_o, 32'd3);
    chk("exec_rsp_valid_low", {31'd0, rsp_valid_o}, 32'd0);
    step();
    drain();

    issue(CMD_ALU, ALU_O_SUB, 3'd4, 3'd1, 3'd1, 32'd0, 1'b1, 32'd0, 1'b1);
    issue(CMD_ALU, ALU_O_SUB, 3'd5, 3'd2, 3'd1, 32'd0, 1'b1, 32'hFFFF_FFFE, 1'b0);
    // LDI must not consult the ALU: idle values during its S_EXEC.
    issue(CMD_LDI, ALU_O_SUB, 3'd1, 3'd1, 3'd2, 32'hF0F0_0000, 1'b1, 32'hF0F0_0000, 1'b0);
    @(negedge clk_i);
    chk("ldi_alu_op_idle", {29'd0, alu_op_o}, {29'd0, ALU_O_ADD});
    chk("ldi_alu_rs_idle", alu_rs_o, 32'd0);
    step();
    issue(CMD_LDI, ALU_O_ADD, 3'd2, 3'd0, 3'd0, 32'h0FF0_0000, 1'b1, 32'h0FF0_0000, 1'b0);
    issue(CMD_ALU, ALU_O_OR, 3'd3, 3'd1, 3'd2, 32'd0, 1'b1, 32'hFFF0_0000, 1'b0);
    issue(CMD_ALU, ALU_O_AND, 3'd4, 3'd1, 3'd2, 32'd0, 1'b1, 32'h00F0_0000, 1'b0);
    issue(CMD_LDI, ALU_O_ADD, 3'd0, 3'd0, 3'd0, 32'd7, 1'b1, 32'd7, 1'b0);
    issue(CMD_ALU, ALU_O_ADD, 3'd6, 3'd0, 3'd0, 32'd0, 1'b1, 32'd0, 1'b1);
    issue(CMD_LDI, ALU_O_ADD, 3'd7, 3'd0, 3'd0, 32'd0, 1'b1, 32'd0, 1'b1);
    issue(cmd_kind_e'(2'd3), ALU_O_ADD, 3'd5, 3'd1, 3'd2, 32'h55, 1'b1, 32'h55, 1'b0);
    drain();

    // Backpressure: response held, pending command not accepted.
    rsp_ready_i = 1'b0;
    issue(CMD_LDI, ALU_O_ADD, 3'd7, 3'd0, 3'd0, 32'h1234, 1'b1, 32'h1234, 1'b0);
    begin
      exp_t eb;
      eb.data = 32'hAB;
      eb.zero = 1'b0;
      eb.rd   = 3'd6;
      exp_q.push_back(eb);
    end
    cmd_valid_i = 1'b1;
    cmd_kind_i  = CMD_LDI;
    cmd_rd_i    = 3'd6;
    cmd_imm_i   = 32'hAB;
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("hold_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
      chk("hold_rsp_data", rsp_data_o, 32'h1234);
      chk("hold_cmd_ready", {31'd0, cmd_ready_o}, 32'd0);
      step();
    end
    rsp_ready_i = 1'b1;
    step();
    @(negedge clk_i);
    chk("release_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
    step();
    cmd_valid_i = 1'b0;
    drain();

    // Read-after-write chain.
    issue(CMD_LDI, ALU_O_ADD, 3'd1, 3'd0, 3'd0, 32'd5, 1'b1, 32'd5, 1'b0);
    issue(CMD_LDI, ALU_O_ADD, 3'd2, 3'd0, 3'd0, 32'd3, 1'b1, 32'd3, 1'b0);
    issue(CMD_ALU, ALU_O_ADD, 3'd3, 3'd1, 3'd2, 32'd0, 1'b1, 32'd8, 1'b0);
    issue(CMD_ALU, ALU_O_ADD, 3'd3, 3'd3, 3'd3, 32'd0, 1'b1, 32'd16, 1'b0);
    drain();

    // Reset during S_EXEC drops the command and clears the regfile.
    issue(CMD_ALU, ALU_O_ADD, 3'd3, 3'd1, 3'd2, 32'd0, 1'b0, 32'd0, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b0;
    step();
    chk("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
    chk("rst_rsp_data", rsp_data_o, 32'd0);
    rst_ni = 1'b1;
    step();
    issue(CMD_ALU, ALU_O_ADD, 3'd3, 3'd1, 3'd2, 32'd0, 1'b1, 32'd0, 1'b1);
    drain();
    repeat (3) step();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d queued responses, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_cmd_ctrl.md
# alu_cmd_ctrl

Command-driven controller that sits upstream of the combinational `alu`. It accepts register-level commands over a valid/ready handshake and reads operands from an internal 8×32 register file. It issues the `alu_operation` and operands to the ALU, captures `result`/`zero`, writes the result back, and returns a response over a second valid/ready handshake. It is the initiator end of the ALU interface.

## Interface
- `NREGS`, 8: register file depth. Fixed power of two; `REG_W = $clog2(NREGS)`.
- `DW`, 32: datapath width. Must equal the ALU width.

Ports:
- `clk_i` in 1: sole clock; all state updates on the rising edge.
- `rst_ni` in 1: reset, asynchronous and active-low.
- `cmd_valid_i` in 1: command present.
- `cmd_ready_o` out 1: controller can accept a command.
- `cmd_kind_i` in `cmd_kind_e`: `CMD_ALU` or `CMD_LDI`.
- `cmd_op_i` in `alu_operation`: ALU operation (`CMD_ALU` only).
- `cmd_rd_i`, `cmd_rs_i`, `cmd_rt_i` in `REG_W` each: destination and source register indices.
- `cmd_imm_i` in `DW`: immediate (`CMD_LDI` only).
- `alu_op_o` out `alu_operation`: to ALU `op_i`.
- `alu_rs_o`, `alu_rt_o` out `DW` each: to ALU `rs_i` and `rt_i`.
- `alu_result_i` in `DW`: from ALU `result_o`.
- `alu_zero_i` in 1: from ALU `zero`.
- `rsp_valid_o` out 1: response present.
- `rsp_ready_i` in 1: downstream accepts the response.
- `rsp_data_o` out `DW`: result written to `rd`.
- `rsp_zero_o` out 1: zero flag of that result.
- `rsp_rd_o` out `REG_W`: destination index echoed.

## Operation
- FSM states: `S_IDLE`, `S_EXEC`, `S_RESP`. Reset state is `S_IDLE`.
- `S_IDLE`:
  - `cmd_ready_o` = 1.
  - On `cmd_valid_i`, latch kind, op, rd, and imm.
  - Latch `opA = R[rs]` and `opB = R[rt]` using a combinational regfile read.
  - Go to `S_EXEC`.
- `S_EXEC`: lasts exactly 1 cycle.
  - `CMD_ALU`: drive `alu_op_o` = latched op, `alu_rs_o` = opA, `alu_rt_o` = opB. At the end of the cycle capture `alu_result_i`/`alu_zero_i` into the response registers.
  - `CMD_LDI`: capture `cmd_imm` as data and `zero = (imm == 0)`. The ALU is not consulted.
  - In both cases, write `R[rd]` with the captured data on the same edge, unless `rd == 0`.
  - Go to `S_RESP`.
- `S_RESP`:
  - `rsp_valid_o` = 1.
  - Hold the `rsp_*` outputs stable until `rsp_ready_i`; then go to `S_IDLE`.
- Outside `S_EXEC`, or for `CMD_LDI`: `alu_op_o` = `ALU_O_ADD`, `alu_rs_o` = `alu_rt_o` = 0.
- `R[0]` reads as 0 always; writes to it are discarded. The response still reports the computed data and zero flag for `rd = 0`.
- Arithmetic is performed by the ALU modulo 2^DW; the controller does no width extension.
- An unknown `cmd_kind_i` is treated as `CMD_LDI`.
- Reset (any time, including mid-command):
  - State goes to `S_IDLE` and all registers, including the regfile, go to 0.
  - The in-flight command is dropped with no response.
  - Reset values: `cmd_ready_o` = 1, `rsp_valid_o` = 0, `rsp_data_o` = 0, `rsp_zero_o` = 0, `rsp_rd_o` = 0, ALU outputs at their idle values.

## Timing
- Accept at edge E0 (`cmd_valid_i && cmd_ready_o`).
- `S_EXEC` occupies E0–E1. At E1 the regfile is written and `rsp_valid_o` rises.
- Response handshake completes at the first edge Ek ≥ E2 with `rsp_ready_i` = 1. `cmd_ready_o` rises after Ek.
- Minimum 3 cycles per command; no overlap between commands.
- Read-after-write is safe without forwarding: the regfile write at E1 precedes the next accept, which is ≥ E2.
- `cmd_ready_o` and `rsp_valid_o` are pure functions of state and never combinationally depend on the `*_valid_i`/`*_ready_i` inputs.
- The ALU path is combinational within the `S_EXEC` cycle; one cycle of ALU delay is budgeted.

## Structure
- Package `definitions` holds the existing `alu_operation` plus the new `cmd_kind_e` (`CMD_ALU`, `CMD_LDI`) and `ctrl_state_e`.
- Sub-module `alu_regfile`:
  - `NREGS`×`DW`, two asynchronous read ports, one synchronous write port.
  - `R[0]` hardwired to zero; async active-low clear.
- The top level holds the FSM, the command/operand latches, and the response registers. It instantiates `alu_regfile`.
- The bench instantiates `alu_cmd_ctrl` with `alu` attached.

## Test plan
- LDI r1=5, LDI r2=3, then ALU ADD rd=3 rs=1 rt=2 → responses (5,0,r1), (3,0,r2), (8,0,r3). During ADD's `S_EXEC`: `alu_op_o`=ADD, `alu_rs_o`=5, `alu_rt_o`=3.
- SUB rd=4 rs=1 rt=1 → `rsp_data_o`=0, `rsp_zero_o`=1. Then SUB rd=5 rs=2 rt=1 → 0xFFFF_FFFE, zero=0.
- LDI r1=0xF0F0_0000, LDI r2=0x0FF0_0000, then OR → 0xFFF0_0000; AND → 0x00F0_0000, zero=0. Then LDI r0=7 → response data 7, followed by ADD rd=6 rs=0 rt=0 → 0, zero=1.
- Hold `rsp_ready_i`=0 for 5 cycles → `rsp_valid_o` and data stay stable, `cmd_ready_o`=0, a pending `cmd_valid_i` is not accepted. Release → handshake, then accept on the next cycle.
- Dependent chain: ADD r3=r1+r2 immediately followed by ADD r3=r3+r3 (r1=5, r2=3) → 8 then 16, confirming read-after-write.
- Assert `rst_ni`=0 during `S_EXEC` → next cycle `rsp_valid_o`=0, `cmd_ready_o`=1, no response emitted. After release, ADD rd=3 rs=1 rt=2 → 0, zero=1 (regfile cleared).
